// File: rtl/inv_key_expand.sv
// -----------------------------------------------------------------------------
// inv_key_expand
//   Decryption-side AES-128 key scheduler. The cipher key is captured on start,
//   the forward schedule runs 10 cycles to reach the round-10 key, then the
//   schedule is walked backwards one round per accepted handshake. Only the
//   current round key is held.
//
//   Optional feature macro: INV_MIXCOL_KEY_EN
//     defined   : rounds 9..1 are output as InvMixColumns(key register)
//                 (equivalent-inverse-cipher form); rounds 10 and 0 raw.
//     undefined : round_key is always the raw key register.
//
//   Ports:
//     clk        in   1    system clock, rising edge
//     reset      in   1    asynchronous, active-low reset
//     start      in   1    capture key_in and begin (IDLE only)
//     key_in     in   128  cipher key, FIPS-197 byte order (w0 = [127:96])
//     busy       out  1    schedule running (forward or emitting)
//     key_valid  out  1    round_key / round_idx valid
//     key_ready  in   1    consumer accepts current round key
//     round_key  out  128  current round key
//     round_idx  out  4    round number of round_key, 10 down to 0
//     done       out  1    one-cycle pulse after round 0 is accepted
// -----------------------------------------------------------------------------

module inv_key_expand_sbox (
   input  logic [7:0] i_addr,
   output logic [7:0] o_dout
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_dout = SBOX[i_addr];
endmodule

module inv_key_expand #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         done
);
   generate
      if (NR != 10) begin : g_nr_check
         $error("inv_key_expand: only NR=10 (AES-128) is supported");
      end
   endgenerate

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FWD  = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   logic [1:0]   r_state;
   logic [127:0] r_key;
   logic [3:0]   r_cnt;
   logic         r_done;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_p3;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [31:0]  w_t;
   logic [7:0]   w_rcon;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;
   logic [127:0] w_fwd_key;
   logic [127:0] w_inv_key;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   // Going backwards, the previous w3 is recovered as w3^w2 and is what
   // feeds the S-boxes; going forwards it is the current w3.
   assign w_p3  = w_w3 ^ w_w2;
   assign w_rot = (r_state == S_FWD) ? {w_w3[23:0], w_w3[31:24]}
                                     : {w_p3[23:0], w_p3[31:24]};

   for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      inv_key_expand_sbox u_sbox (
         .i_addr (w_rot[8*gi +: 8]),
         .o_dout (w_sub[8*gi +: 8])
      );
   end

   // Rcon indexed by the round the forward step produces (or the inverse
   // step leaves), i.e. the counter value in both directions.
   always_comb begin
      w_rcon = 8'h00;
      case (r_cnt)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_t = w_sub ^ {w_rcon, 24'h000000};

   assign w_n0 = w_w0 ^ w_t;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;
   assign w_fwd_key = {w_n0, w_n1, w_n2, w_n3};

   assign w_inv_key = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_key   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_key   <= key_in;
                  r_cnt   <= 4'd1;
                  r_state <= S_FWD;
               end
            end
            S_FWD: begin
               r_key <= w_fwd_key;
               if (r_cnt == LAST_ROUND) begin
                  r_state <= S_EMIT;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_EMIT: begin
               if (key_ready) begin
                  if (r_cnt != 4'd0) begin
                     r_key <= w_inv_key;
                     r_cnt <= r_cnt - 4'd1;
                  end else begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign key_valid = (r_state == S_EMIT);
   assign round_idx = r_cnt;
   assign done      = r_done;

`ifdef INV_MIXCOL_KEY_EN
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
              mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
              muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
              mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
   endfunction

   logic [127:0] w_mix_key;
   assign w_mix_key = {inv_mix_col(w_w0), inv_mix_col(w_w1),
                       inv_mix_col(w_w2), inv_mix_col(w_w3)};

   assign round_key = ((r_cnt != 4'd0) && (r_cnt != LAST_ROUND)) ? w_mix_key : r_key;
`else
   assign round_key = r_key;
`endif

endmodule

// File: doc/inv_key_expand.md
Name: inv_key_expand

Overview:
- Decryption-side AES-128 key scheduler. Delivers round keys in reverse order (round 10 down to round 0) to the inverse-cipher datapath.
- On `start`, the block captures the cipher key and runs the forward schedule internally for 10 cycles to reach the round-10 key.
- It then walks the schedule backwards one round per accepted handshake. All 11 round keys are never stored; only the current key is held.
- Sits between the key-load interface and the inverse round engine, mirroring the forward expander used by encryption.

Parameters:
- NR, 10, number of AES rounds. Only 10 (AES-128) is legal; any other value is a elaboration-time error.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; captures key_in. Ignored unless state is IDLE.
- key_in  input  128  cipher key, FIPS-197 byte order (key_in[127:120] = byte 0, key_in[127:96] = w0)
- busy  output  1  high in FWD and EMIT
- key_valid  output  1  round_key / round_idx are valid (EMIT only)
- key_ready  input  1  consumer accepts the current round key
- round_key  output  128  current round key
- round_idx  output  4  round number of round_key, counting 10 down to 0
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async assert, any state): state=IDLE, key register=0, round counter=0, busy=0, key_valid=0, round_key=0, round_idx=0, done=0.
- Four SBox instances (addr 8b in, dout 8b out) are shared between the forward and inverse steps through an input mux selected by state.
- Forward step, Rcon indexed by target round r (01,02,04,08,10,20,40,80,1b,36), from current words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
- Inverse step, from round r to round r-1:
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
- FSM:
  - IDLE: start=1 → load key_in, cnt=1, go to FWD.
  - FWD: each cycle apply the forward step with r=cnt, then cnt++. The step with cnt=10 goes to EMIT with cnt=10. This is 10 cycles in total.
  - EMIT: key_valid=1, round_key=key register, round_idx=cnt.
    - Handshake key_valid & key_ready with cnt>0: apply the inverse step with r=cnt, then cnt--.
    - Handshake with cnt=0: go to IDLE, pulse done for 1 cycle, drop key_valid.
- Latency: start accepted at edge T → key_valid=1 with round_idx=10 after edge T+10. With key_ready held high, 11 consecutive keys, one per cycle; done asserts in the cycle after round 0 is accepted.
- round_key / round_idx hold stable while key_valid=1 and key_ready=0 (backpressure, any duration).
- start while busy: ignored, no effect on state or key.
- start in the same cycle as the round-0 handshake: ignored; start must be reissued once IDLE.
- key_ready while key_valid=0: ignored.
- In IDLE, round_key keeps the round-0 key of the last run (never cleared except by reset); key_valid=0.

Optional Feature:
- Macro INV_MIXCOL_KEY_EN:
  - Defined: for round_idx 9..1, round_key outputs InvMixColumns(key register), i.e. the equivalent-inverse-cipher key form. Rounds 10 and 0 are output raw. Internal schedule state is unaffected. The transform is combinational on the output path, so latency is unchanged.
  - Undefined: round_key is always the raw key register.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, key_ready=1:
  - key_valid rises 10 cycles after start with round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: round_idx=9, ac7766f319fadc2128d12941575c006e.
  - round_idx=1: a0fafe1788542cb123a339392a6c7605.
  - round_idx=0: 2b7e1516…4f3c, then done pulse.
- Backpressure: same key, key_ready toggled randomly → sequence identical to the previous case; key held stable while key_ready=0; exactly 11 handshakes, then one done.
- start pulsed during FWD and during EMIT with a different key_in → ignored; output sequence still matches the FIPS key.
- reset deasserted low mid-EMIT at round_idx=5 → all outputs 0 immediately (async). A new start with key 000…0 gives round_idx=10 key b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back: start issued the cycle after done → second run begins normally with correct latency.
- With INV_MIXCOL_KEY_EN defined, FIPS key → round_idx=10 output unchanged (d014f9a8…); round_idx 9..1 outputs = InvMixColumns(raw key) per the golden model; round 0 output raw.
